fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC loaded at reset when the boot feature is compiled out.
REQ-002 Parameter IMM_BIT, default 0: bit of the first instruction word that flags a two-word (immediate) instruction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 imem_addr  output  16  instruction memory word address, driven combinationally from the current state.
REQ-006 imem_rdata  input  16  instruction word at imem_addr, valid in the same cycle.
REQ-007 stall  input  1  decode hazard; hold PC, state and IF/ID contents.
REQ-008 redirect  input  1  taken branch, jump or return; flush and reload PC.
REQ-009 redirect_pc  input  16  target PC, sampled when redirect=1.
REQ-010 ifid_instr  output  16  registered instruction word to decode.
REQ-011 ifid_imm  output  16  registered immediate word; 16'h0000 for one-word instructions.
REQ-012 ifid_pc  output  16  registered address of the instruction following the delivered one.
REQ-013 ifid_valid  output  1  registered; 1 = IF/ID holds a real instruction, 0 = bubble.

Function
REQ-014 FSM states: BOOT (only with the macro), FIRST, SECOND.
REQ-015 FIRST: imem_addr=PC. If imem_rdata[IMM_BIT]=0: IF/ID <= {word, 16'h0000, PC+1, valid=1}; PC <= PC+1; stay in FIRST.
REQ-016 FIRST with imem_rdata[IMM_BIT]=1: hold_reg <= word; PC <= PC+1; IF/ID <= bubble; go to SECOND.
REQ-017 SECOND: imem_addr=PC; IF/ID <= {hold_reg, imem_rdata, PC+1, valid=1}; PC <= PC+1; go to FIRST.
REQ-018 Bubble = ifid_instr 16'h0000, ifid_imm 16'h0000, ifid_valid 0; ifid_pc holds its previous value.
REQ-019 Priority when events coincide: reset > redirect > stall > normal advance.
REQ-020 redirect=1: PC <= redirect_pc; state <= FIRST; IF/ID <= bubble; any half-fetched hold_reg word is discarded; this applies even when stall=1.
REQ-021 stall=1 without redirect: PC, state, hold_reg and all ifid_* registers hold their values.
REQ-022 PC arithmetic is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000 with no flag.
REQ-023 ifid_valid is never 1 for a first word whose immediate has not yet been fetched.

Reset
REQ-024 While rst=0: all ifid_* = 0; hold_reg = 0; PC = RESET_PC; state = FIRST (BOOT with the macro).
REQ-025 Reset asserted mid-instruction (state SECOND) drops the pending word; the first cycle after release fetches from the reset PC.

Configuration
REQ-026 Macro FETCH_RESET_VECTOR_EN defined: reset enters BOOT; BOOT drives imem_addr=16'h0000, loads PC <= imem_rdata, keeps IF/ID as a bubble and moves to FIRST after exactly one cycle; stall is ignored in BOOT and redirect is also ignored in BOOT.
REQ-027 Macro undefined: BOOT does not exist; PC resets to RESET_PC; the first fetch occurs in the first cycle after reset release.

Structure
REQ-028 Shared package proc_pkg holds WORD_W=16, NOP_WORD=16'h0000, the IMM_BIT default and the fetch state enum.
REQ-029 One sub-module, ifid_reg, is natural: the IF/ID pipeline register with hold (stall) and bubble (flush) controls; the PC/FSM logic stays in fetch_stage.

Verification
REQ-030 Macro off, RESET_PC=0, memory words 0..2 one-word -> ifid_valid=1 from the 1st edge after reset release; ifid_pc = 1, 2, 3 on successive edges.
REQ-031 Word 4 = 16'h0C01 (bit0=1), word 5 = 16'h1234 -> one bubble cycle, then ifid_instr=16'h0C01, ifid_imm=16'h1234, ifid_pc=6.
REQ-032 stall=1 for 3 cycles with ifid_instr=16'h2000 -> all ifid_* and imem_addr constant for those cycles; normal advance resumes on the next edge after release.
REQ-033 redirect=1 with redirect_pc=16'h0040 while in SECOND, stall=1 in the same cycle -> bubble; next fetch address is 16'h0040; the held word is never delivered.
REQ-034 Macro on, imem[0]=16'h0100 -> one BOOT bubble cycle, then imem_addr=16'h0100; PC=16'hFFFF one-word fetch -> ifid_pc=16'h0000.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg -- shared definitions for the processor front end.
//   WORD_W          : instruction / address word width
//   NOP_WORD        : encoding loaded into IF/ID for a bubble
//   IMM_BIT_DEFAULT : default bit position of the two-word flag
//   fetch_state_t   : fetch FSM state encoding
// Configuration macro: FETCH_RESET_VECTOR_EN adds the BOOT state and makes
// it the reset state.
package proc_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;
  localparam int IMM_BIT_DEFAULT = 0;

`ifdef FETCH_RESET_VECTOR_EN
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } fetch_state_t;
  localparam fetch_state_t RESET_STATE = ST_BOOT;
`else
  typedef enum logic [1:0] {
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } fetch_state_t;
  localparam fetch_state_t RESET_STATE = ST_FIRST;
`endif

  // Next sequential word address; wraps modulo 2^16 without a flag.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg -- IF/ID pipeline register.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_flush           : load a bubble (instr/imm = NOP, valid = 0, pc kept)
//   i_hold            : keep every field (used while decode stalls)
//   i_instr/i_imm/i_pc: fields captured when neither flush nor hold
//   o_instr/o_imm/o_pc/o_valid : registered IF/ID contents
// Flush has priority over hold so a redirect during a stall still squashes.
module ifid_reg
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_imm,
  input  logic [WORD_W-1:0] i_pc,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_imm,
  output logic [WORD_W-1:0] o_pc,
  output logic              o_valid
);

  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_imm;
  logic [WORD_W-1:0] r_pc;
  logic              r_valid;

  // IF/ID storage: flush > hold > load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= NOP_WORD;
      r_imm   <= NOP_WORD;
      r_pc    <= 16'h0000;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_WORD;
      r_imm   <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_imm   <= i_imm;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_imm   = r_imm;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch with one- and two-word instructions.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   imem_addr / imem_rdata: instruction memory, same-cycle read data
//   stall                 : hold PC, FSM, hold word and IF/ID
//   redirect, redirect_pc : flush and reload PC (wins over stall)
//   ifid_instr/imm/pc/valid : registered IF/ID outputs
// Parameters: RESET_PC (reset PC without boot vector), IMM_BIT (two-word flag).
// Configuration macro: FETCH_RESET_VECTOR_EN -- reset enters BOOT, which reads
// word 0 as the start PC, issues a bubble and ignores stall/redirect.
module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IMM_BIT  = IMM_BIT_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_imm,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_next_pc;
  logic [WORD_W-1:0] r_hold;
  logic [WORD_W-1:0] w_next_hold;
  logic [WORD_W-1:0] w_pc_inc;
  logic              w_flush;
  logic              w_stall_hold;
  logic [WORD_W-1:0] w_instr;
  logic [WORD_W-1:0] w_imm;

  assign w_pc_inc = pc_inc(r_pc);

  // FSM, PC and hold-word state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RESET_STATE;
      r_pc    <= RESET_PC;
      r_hold  <= NOP_WORD;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_hold  <= w_next_hold;
    end
  end

  // Next-state, memory address and IF/ID control.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_hold  = r_hold;
    imem_addr    = r_pc;
    w_flush      = 1'b0;
    w_stall_hold = 1'b0;
    w_instr      = imem_rdata;
    w_imm        = NOP_WORD;

`ifdef FETCH_RESET_VECTOR_EN
    if (r_state == ST_BOOT) begin
      // Boot vector: word 0 holds the start PC; stall and redirect ignored.
      imem_addr    = 16'h0000;
      w_next_pc    = imem_rdata;
      w_flush      = 1'b1;
      w_next_state = ST_FIRST;
    end else
`endif
    if (redirect) begin
      // A half-fetched two-word instruction is dropped here.
      w_next_pc    = redirect_pc;
      w_next_state = ST_FIRST;
      w_next_hold  = NOP_WORD;
      w_flush      = 1'b1;
    end else if (stall) begin
      w_stall_hold = 1'b1;
    end else begin
      case (r_state)
        ST_FIRST: begin
          w_next_pc = w_pc_inc;
          if (imem_rdata[IMM_BIT]) begin
            // Opcode word parked until its immediate arrives.
            w_next_hold  = imem_rdata;
            w_flush      = 1'b1;
            w_next_state = ST_SECOND;
          end else begin
            w_next_state = ST_FIRST;
          end
        end
        ST_SECOND: begin
          w_instr      = r_hold;
          w_imm        = imem_rdata;
          w_next_pc    = w_pc_inc;
          w_next_state = ST_FIRST;
        end
        default: begin
          w_flush      = 1'b1;
          w_next_state = ST_FIRST;
        end
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_hold  (w_stall_hold),
    .i_instr (w_instr),
    .i_imm   (w_imm),
    .i_pc    (w_pc_inc),
    .o_instr (ifid_instr),
    .o_imm   (ifid_imm),
    .o_pc    (ifid_pc),
    .o_valid (ifid_valid)
  );

endmodule
